bit_deserializer: RTL and testbench

- Collects a serial stream of single bits into a parallel word of WordWidth bits, using valid/ready handshakes on both sides.
- It is the widening counterpart of the bit reducer: the reducer collapses N bits into one, this block expands one bit per transfer into N.
- Sits between serial sources (bit-banged peripherals, debug/scan links) and word-wide datapaths.
- A sideband last flag closes a word early, zero-padded.

---
 rtl/bit_deserializer.sv | 86 ++++++++
 tb/tb_bit_deserializer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bit_deserializer.sv
// Serial-to-parallel bit collector with valid/ready on both sides; bit_in_last closes a word early (zero-padded).
// Optional running parity on the output word is built when BIT_DESERIALIZER_PARITY_EN is defined.
module bit_deserializer #(
  parameter int unsigned WordWidth = 8,
  parameter bit          MsbFirst  = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               bit_in,
  input  logic                               bit_in_last,
  input  logic                               bit_in_valid,
  output logic                               bit_in_ready,
  output logic [WordWidth-1:0]               word_out,
  output logic [$clog2(WordWidth+1)-1:0]     word_out_bits,
  output logic                               word_out_valid,
  input  logic                               word_out_ready,
  output logic                               word_out_parity
);

  localparam int unsigned CntW  = $clog2(WordWidth);
  localparam int unsigned BitsW = $clog2(WordWidth + 1);

  logic [CntW-1:0]      cnt;
  logic [CntW-1:0]      pos;
  logic [WordWidth-1:0] acc;
  logic [WordWidth-1:0] merged;
  logic                 cand;
  logic                 in_xfer;
  logic                 complete;
  logic                 out_xfer;

  // Only a completing bit can stall; partial bits keep filling acc while a word waits.
  always_comb begin
    cand         = (cnt == CntW'(WordWidth - 1)) | bit_in_last;
    bit_in_ready = ~(cand & word_out_valid & ~word_out_ready);
    in_xfer      = bit_in_valid & bit_in_ready;
    complete     = in_xfer & cand;
    out_xfer     = word_out_valid & word_out_ready;
    pos          = MsbFirst ? (CntW'(WordWidth - 1) - cnt) : cnt;
    merged       = acc;
    merged[pos]  = bit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc            <= '0;
      cnt            <= '0;
      word_out       <= '0;
      word_out_bits  <= '0;
      word_out_valid <= 1'b0;
    end else if (complete) begin
      word_out       <= merged;
      word_out_bits  <= BitsW'(cnt) + BitsW'(1);
      word_out_valid <= 1'b1;
      acc            <= '0;
      cnt            <= '0;
    end else begin
      if (out_xfer) begin
        word_out_valid <= 1'b0;
      end
      if (in_xfer) begin
        acc <= merged;
        cnt <= cnt + CntW'(1);
      end
    end
  end

`ifdef BIT_DESERIALIZER_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (rst) begin
      par             <= 1'b0;
      word_out_parity <= 1'b0;
    end else if (complete) begin
      par             <= 1'b0;
      word_out_parity <= par ^ bit_in;
    end else if (in_xfer) begin
      par <= par ^ bit_in;
    end
  end
`else
  assign word_out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer: LSB/MSB placement, early last, backpressure, mid-word reset.
module tb_bit_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_in_last;
  logic       bit_in_valid;
  logic       bit_in_ready;
  logic [7:0] word_out;
  logic [3:0] word_out_bits;
  logic       word_out_valid;
  logic       word_out_ready;
  logic       word_out_parity;

  logic       msb_ready;
  logic [7:0] msb_word;
  logic [3:0] msb_bits;
  logic       msb_valid;
  logic       msb_parity;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  bit_deserializer #(.WordWidth(8), .MsbFirst(1'b0)) dut (
    .clk             (clk),
    .rst             (rst),
    .bit_in          (bit_in),
    .bit_in_last     (bit_in_last),
    .bit_in_valid    (bit_in_valid),
    .bit_in_ready    (bit_in_ready),
    .word_out        (word_out),
    .word_out_bits   (word_out_bits),
    .word_out_valid  (word_out_valid),
    .word_out_ready  (word_out_ready),
    .word_out_parity (word_out_parity)
  );

  bit_deserializer #(.WordWidth(8), .MsbFirst(1'b1)) dut_msb (
    .clk             (clk),
    .rst             (rst),
    .bit_in          (bit_in),
    .bit_in_last     (bit_in_last),
    .bit_in_valid    (bit_in_valid),
    .bit_in_ready    (msb_ready),
    .word_out        (msb_word),
    .word_out_bits   (msb_bits),
    .word_out_valid  (msb_valid),
    .word_out_ready  (1'b1),
    .word_out_parity (msb_parity)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_par(input logic [7:0] w);
`ifdef BIT_DESERIALIZER_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  task automatic send(input logic b, input logic last);
    bit_in       = b;
    bit_in_last  = last;
    bit_in_valid = 1'b1;
    step();
    bit_in_valid = 1'b0;
    bit_in_last  = 1'b0;
  endtask

  logic [7:0] pat;

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_in_last = 1'b0; bit_in_valid = 1'b0; word_out_ready = 1'b1;
    step(); step();
    check("rst_valid",  word_out_valid,  1'b0);
    check("rst_word",   word_out,        8'h00);
    check("rst_bits",   word_out_bits,   4'd0);
    check("rst_parity", word_out_parity, 1'b0);
    check("rst_ready",  bit_in_ready,    1'b1);
    rst = 1'b0;
    step();

    // Full word 1,0,1,1,0,0,0,1 on consecutive cycles
    pat = 8'b1000_1101;
    for (int i = 0; i < 8; i++) begin
      bit_in = pat[i]; bit_in_valid = 1'b1; bit_in_last = 1'b0;
      step();
      if (i == 6) check("lsb_not_early", word_out_valid, 1'b0);
    end
    bit_in_valid = 1'b0;
    check("lsb_valid",  word_out_valid,  1'b1);
    check("lsb_word",   word_out,        8'h8D);
    check("lsb_bits",   word_out_bits,   4'd8);
    check("lsb_parity", word_out_parity, exp_par(8'h8D));
    check("msb_valid",  msb_valid,       1'b1);
    check("msb_word",   msb_word,        8'hB1);
    check("msb_bits",   msb_bits,        4'd8);
    check("msb_parity", msb_parity,      exp_par(8'hB1));
    step();
    check("drain_valid", word_out_valid, 1'b0);

    // last without valid must be ignored
    bit_in_last = 1'b1; bit_in = 1'b1;
    step();
    bit_in_last = 1'b0;
    check("last_ignored", word_out_valid, 1'b0);

    // Early last on the third bit, then a one-bit word
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b1);
    check("early_valid",  word_out_valid,  1'b1);
    check("early_word",   word_out,        8'h03);
    check("early_bits",   word_out_bits,   4'd3);
    check("early_parity", word_out_parity, exp_par(8'h03));
    send(1'b1, 1'b1);
    check("one_word",   word_out,        8'h01);
    check("one_bits",   word_out_bits,   4'd1);
    check("one_parity", word_out_parity, exp_par(8'h01));
    step();
    check("one_drain", word_out_valid, 1'b0);

    // Backpressure: 0xFF held while 0x5A fills behind it
    word_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0);
    check("bp_first_word",  word_out,       8'hFF);
    check("bp_first_valid", word_out_valid, 1'b1);
    pat = 8'h5A;
    for (int i = 0; i < 7; i++) begin
      bit_in = pat[i]; bit_in_valid = 1'b1;
      check($sformatf("bp_ready_%0d", i + 9), bit_in_ready, 1'b1);
      step();
      check($sformatf("bp_hold_%0d", i + 9), word_out, 8'hFF);
    end
    bit_in = pat[7];
    check("bp_stall_ready", bit_in_ready, 1'b0);
    step();
    check("bp_stall_word", word_out, 8'hFF);
    check("bp_stall_bits", word_out_bits, 4'd8);
    word_out_ready = 1'b1;
    #1;
    check("bp_release_ready", bit_in_ready, 1'b1);
    step();
    bit_in_valid = 1'b0; word_out_ready = 1'b0;
    check("bp_second_valid",  word_out_valid,  1'b1);
    check("bp_second_word",   word_out,        8'h5A);
    check("bp_second_bits",   word_out_bits,   4'd8);
    check("bp_second_parity", word_out_parity, exp_par(8'h5A));
    word_out_ready = 1'b1;
    step();

    // Reset mid-word discards the partial accumulation
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    rst = 1'b1;
    step();
    check("mid_rst_valid", word_out_valid, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_valid", word_out_valid, 1'b0);
    pat = 8'h01;
    for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
    check("post_rst_word",   word_out,        8'h01);
    check("post_rst_bits",   word_out_bits,   4'd8);
    check("post_rst_parity", word_out_parity, exp_par(8'h01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
